sram_byte_bridge: RTL and testbench

- Sits between the chipset memory port of the system and the external 2 MB 8-bit asynchronous SRAM pins (21-bit address, 8-bit data, WE_n only, OE/CE tied active).
- Converts 16-bit word requests with byte enables into one or two timed byte cycles on the SRAM.
- Runs in the 100 MHz domain.
- Tristate data pin is split into out/oe/in; the buffer is instantiated at top level.

---
 rtl/sram_bridge_pkg.sv | 22 ++
 rtl/sram_byte_bridge.sv | 165 ++++++++++++++++
 tb/tb_sram_byte_bridge.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_bridge_pkg.sv
// Shared types and constants for the 16-bit-word to 8-bit async SRAM bridge.
package sram_bridge_pkg;

    localparam int ADDR_W_DEF     = 21;
    localparam int STROBE_CYC_DEF = 2;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        ACK    = 3'd4
    } state_t;

    function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic lane);
        return lane ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/sram_byte_bridge.sv
// Splits 16-bit word requests with byte enables into timed byte cycles on an
// 8-bit asynchronous SRAM; every pin is driven straight from a flop.
//
// state  | meaning
// IDLE   | waiting for req; busy=0
// SETUP  | address (and write data) presented, WE_n still high
// STROBE | WE_n low for writes / read data settling, STROBE_CYC cycles
// HOLD   | WE_n high again, address and data held; pick next lane or finish
// ACK    | one-cycle completion pulse, data bus released
module sram_byte_bridge
    import sram_bridge_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int STROBE_CYC = STROBE_CYC_DEF
) (
    input  logic              clk_100,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-2:0] addr,
    input  logic [1:0]        be,
    input  logic [15:0]       wdata,
    output logic              busy,
    output logic              ack,
    output logic [15:0]       rdata,
    output logic [ADDR_W-1:0] SRAM_A,
    output logic [7:0]        sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [7:0]        sram_dq_i,
    output logic              SRAM_WE_n
);

    localparam int               CNT_W    = $clog2(STROBE_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STROBE_CYC - 1);

    if (STROBE_CYC < 1) begin : g_bad_strobe
        $error("sram_byte_bridge: STROBE_CYC must be at least 1");
    end

    state_t            r_state;
    logic              r_we;
    logic [ADDR_W-2:0] r_addr;
    logic              r_be_hi;
    logic [7:0]        r_wdata_hi;
    logic              r_lane;
    logic [CNT_W-1:0]  r_cnt;
    logic [15:0]       r_rbuf;
    logic              r_busy;
    logic              r_ack;
    logic [15:0]       r_rdata;
    logic [ADDR_W-1:0] r_sram_a;
    logic [7:0]        r_dq_o;
    logic              r_dq_oe;
    logic              r_we_n;

    logic              w_first_lane;

    assign w_first_lane = be[0] ? LANE_LO : LANE_HI;

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_be_hi    <= 1'b0;
            r_wdata_hi <= '0;
            r_lane     <= LANE_LO;
            r_cnt      <= '0;
            r_rbuf     <= '0;
            r_busy     <= 1'b0;
            r_ack      <= 1'b0;
            r_rdata    <= '0;
            r_sram_a   <= '0;
            r_dq_o     <= '0;
            r_dq_oe    <= 1'b0;
            r_we_n     <= 1'b1;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_we       <= we;
                        r_addr     <= addr;
                        r_be_hi    <= be[1];
                        r_wdata_hi <= wdata[15:8];
                        r_rbuf     <= '0;
                        r_busy     <= 1'b1;
                        if (be == 2'b00) begin
                            r_state <= ACK;
                            r_ack   <= 1'b1;
                        end else begin
                            r_state  <= SETUP;
                            r_lane   <= w_first_lane;
                            r_sram_a <= {addr, w_first_lane};
                            if (we) begin
                                r_dq_o  <= lane_byte(wdata, w_first_lane);
                                r_dq_oe <= 1'b1;
                            end
                        end
                    end
                end
                SETUP: begin
                    r_state <= STROBE;
                    r_cnt   <= CNT_LOAD;
                    if (r_we) begin
                        r_we_n <= 1'b0;
                    end
                end
                STROBE: begin
                    if (r_cnt == '0) begin
                        r_state <= HOLD;
                        r_we_n  <= 1'b1;
                        // Read data has settled for the whole strobe window by now.
                        if (!r_we) begin
                            if (r_lane == LANE_HI) begin
                                r_rbuf[15:8] <= sram_dq_i;
                            end else begin
                                r_rbuf[7:0] <= sram_dq_i;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (r_lane == LANE_LO && r_be_hi) begin
                        r_state  <= SETUP;
                        r_lane   <= LANE_HI;
                        r_sram_a <= {r_addr, LANE_HI};
                        if (r_we) begin
                            r_dq_o <= r_wdata_hi;
                        end
                    end else begin
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                        r_dq_oe <= 1'b0;
                        // Disabled lanes stay zero because r_rbuf is cleared on accept.
                        if (!r_we) begin
                            r_rdata <= r_rbuf;
                        end
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_dq_oe <= 1'b0;
                    r_we_n  <= 1'b1;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign ack        = r_ack;
    assign rdata      = r_rdata;
    assign SRAM_A     = r_sram_a;
    assign sram_dq_o  = r_dq_o;
    assign sram_dq_oe = r_dq_oe;
    assign SRAM_WE_n  = r_we_n;

endmodule

// File: tb/tb_sram_byte_bridge.sv
// Self-checking bench for sram_byte_bridge: a byte-array SRAM model on the pins
// and a word-level reference model of what each request should do.
module tb_sram_byte_bridge;

    localparam int AW = 21;
    localparam int SC = 2;

    logic          clk_100 = 1'b0;
    logic          rst_n   = 1'b0;
    logic          req     = 1'b0;
    logic          we      = 1'b0;
    logic [AW-2:0] addr    = '0;
    logic [1:0]    be      = '0;
    logic [15:0]   wdata   = '0;
    logic          busy;
    logic          ack;
    logic [15:0]   rdata;
    logic [AW-1:0] SRAM_A;
    logic [7:0]    sram_dq_o;
    logic          sram_dq_oe;
    logic [7:0]    sram_dq_i;
    logic          SRAM_WE_n;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk_100 = ~clk_100;

    sram_byte_bridge #(.ADDR_W(AW), .STROBE_CYC(SC)) dut (
        .clk_100    (clk_100),
        .rst_n      (rst_n),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .be         (be),
        .wdata      (wdata),
        .busy       (busy),
        .ack        (ack),
        .rdata      (rdata),
        .SRAM_A     (SRAM_A),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_i  (sram_dq_i),
        .SRAM_WE_n  (SRAM_WE_n)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    logic [7:0] sram_mem [int];
    logic [7:0] ref_mem  [int];
    wr_t        wr_log[$];
    int         ack_seen  = 0;
    int         oe_cycles = 0;
    int         oe_bad    = 0;
    int         pin_race  = 0;
    int         we_no_oe  = 0;
    logic [AW-1:0] prev_a    = '0;
    logic          prev_we_n = 1'b1;
    logic [15:0]   model_rdata = 16'h0000;

    function automatic logic [7:0] dflt(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
    endfunction

    function automatic int exp_lat(input logic [1:0] b);
        int n;
        n = int'(b[0]) + int'(b[1]);
        return (n == 0) ? 1 : n * (SC + 2) + 1;
    endfunction

    // Asynchronous SRAM: read data follows the address pins.
    always @(SRAM_A or negedge clk_100)
        sram_dq_i = sram_mem.exists(int'(SRAM_A)) ? sram_mem[int'(SRAM_A)] : dflt(SRAM_A);

    always @(negedge clk_100) begin
        wr_t e;
        if (rst_n) begin
            if (!SRAM_WE_n) begin
                e.a = SRAM_A;
                e.d = sram_dq_o;
                wr_log.push_back(e);
                if (sram_dq_oe) sram_mem[int'(SRAM_A)] = sram_dq_o;
                else            we_no_oe++;
            end
            if (sram_dq_oe)                              oe_cycles++;
            if (ack && sram_dq_oe)                       oe_bad++;
            if (SRAM_A !== prev_a && SRAM_WE_n !== prev_we_n) pin_race++;
            if (ack)                                     ack_seen++;
        end
        prev_a    = SRAM_A;
        prev_we_n = SRAM_WE_n;
    end

    task automatic do_txn(input logic t_we, input logic [AW-2:0] t_addr, input logic [1:0] t_be,
                          input logic [15:0] t_wd, output int lat, output logic [15:0] rd);
        @(negedge clk_100); #1;
        req = 1'b1; we = t_we; addr = t_addr; be = t_be; wdata = t_wd;
        @(posedge clk_100); #2;
        req = 1'b0; we = 1'($urandom); addr = (AW-1)'($urandom); be = 2'($urandom); wdata = 16'($urandom);
        lat = 1;
        while (ack !== 1'b1 && lat < 40) begin
            @(posedge clk_100); #2;
            lat++;
        end
        rd = rdata;
        @(negedge clk_100); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk_100);
        #2;
        chk_cnt++; if (busy !== 1'b0)       $display("FAIL reset_busy: got %b want 0", busy);             else pass_cnt++;
        chk_cnt++; if (ack !== 1'b0)        $display("FAIL reset_ack: got %b want 0", ack);               else pass_cnt++;
        chk_cnt++; if (rdata !== 16'h0)     $display("FAIL reset_rdata: got %h want 0000", rdata);        else pass_cnt++;
        chk_cnt++; if (SRAM_A !== '0)       $display("FAIL reset_addr: got %h want 000000", SRAM_A);      else pass_cnt++;
        chk_cnt++; if (sram_dq_o !== 8'h0)  $display("FAIL reset_dq_o: got %h want 00", sram_dq_o);       else pass_cnt++;
        chk_cnt++; if (sram_dq_oe !== 1'b0) $display("FAIL reset_dq_oe: got %b want 0", sram_dq_oe);      else pass_cnt++;
        chk_cnt++; if (SRAM_WE_n !== 1'b1)  $display("FAIL reset_we_n: got %b want 1", SRAM_WE_n);        else pass_cnt++;
        @(negedge clk_100);
        rst_n = 1'b1;
        repeat (2) @(posedge clk_100);
        #2;
        chk_cnt++; if (busy !== 1'b0 || SRAM_WE_n !== 1'b1)
            $display("FAIL reset_release_idle: got busy=%b we_n=%b want busy=0 we_n=1", busy, SRAM_WE_n); else pass_cnt++;
    endtask

    task automatic test_word_write();
        int lat, oe0, race0, ack0, bad;
        logic [15:0] rd;
        wr_log.delete();
        oe0 = oe_cycles; race0 = pin_race; ack0 = ack_seen;
        do_txn(1'b1, 20'h00010, 2'b11, 16'hBEEF, lat, rd);
        ref_mem[32'h20] = 8'hEF;
        ref_mem[32'h21] = 8'hBE;
        chk_cnt++; if (lat !== 9) $display("FAIL word_write_latency: got %0d want 9", lat); else pass_cnt++;
        chk_cnt++; if (wr_log.size() !== 2 * SC)
            $display("FAIL word_write_strobe_cycles: got %0d want %0d", wr_log.size(), 2 * SC); else pass_cnt++;
        bad = 0;
        foreach (wr_log[i]) begin
            if (i < SC && (wr_log[i].a !== 21'h00020 || wr_log[i].d !== 8'hEF)) bad++;
            if (i >= SC && (wr_log[i].a !== 21'h00021 || wr_log[i].d !== 8'hBE)) bad++;
        end
        chk_cnt++; if (bad != 0) $display("FAIL word_write_pins: got %0d bad strobe cycles want 0", bad); else pass_cnt++;
        chk_cnt++; if (sram_mem[32'h20] !== 8'hEF || sram_mem[32'h21] !== 8'hBE)
            $display("FAIL word_write_mem: got %h%h want BEEF", sram_mem[32'h21], sram_mem[32'h20]); else pass_cnt++;
        chk_cnt++; if (oe_cycles - oe0 !== 2 * (SC + 2))
            $display("FAIL word_write_oe_cycles: got %0d want %0d", oe_cycles - oe0, 2 * (SC + 2)); else pass_cnt++;
        chk_cnt++; if (pin_race !== race0 || we_no_oe !== 0 || oe_bad !== 0)
            $display("FAIL word_write_pin_rules: got race=%0d we_no_oe=%0d oe_at_ack=%0d want 0", pin_race - race0, we_no_oe, oe_bad); else pass_cnt++;
        chk_cnt++; if (ack_seen - ack0 !== 1) $display("FAIL word_write_ack_count: got %0d want 1", ack_seen - ack0); else pass_cnt++;
    endtask

    task automatic test_word_read();
        int lat, oe0;
        logic [15:0] rd;
        wr_log.delete();
        oe0 = oe_cycles;
        do_txn(1'b0, 20'h00010, 2'b11, 16'h0000, lat, rd);
        model_rdata = {ref_rd(21'h21), ref_rd(21'h20)};
        chk_cnt++; if (rd !== 16'hBEEF) $display("FAIL word_read_data: got %h want BEEF", rd); else pass_cnt++;
        chk_cnt++; if (lat !== 9) $display("FAIL word_read_latency: got %0d want 9", lat); else pass_cnt++;
        chk_cnt++; if (oe_cycles !== oe0 || wr_log.size() !== 0)
            $display("FAIL word_read_bus_quiet: got oe=%0d strobes=%0d want 0 0", oe_cycles - oe0, wr_log.size()); else pass_cnt++;
    endtask

    task automatic test_byte_write();
        int lat, bad;
        logic [15:0] rd;
        wr_log.delete();
        do_txn(1'b1, 20'h7FFFF, 2'b10, 16'h1234, lat, rd);
        ref_mem[32'h0FFFFF] = 8'h12;
        chk_cnt++; if (lat !== 5) $display("FAIL byte_write_latency: got %0d want 5", lat); else pass_cnt++;
        bad = 0;
        foreach (wr_log[i]) if (wr_log[i].a !== 21'h0FFFFF || wr_log[i].d !== 8'h12) bad++;
        chk_cnt++; if (wr_log.size() !== SC || bad != 0)
            $display("FAIL byte_write_pins: got %0d strobes %0d bad want %0d 0", wr_log.size(), bad, SC); else pass_cnt++;
        chk_cnt++; if (sram_mem.exists(32'h0FFFFE))
            $display("FAIL byte_write_neighbour: got written %h want untouched", sram_mem[32'h0FFFFE]); else pass_cnt++;
        // Top word address with the high lane lands on the last SRAM byte.
        wr_log.delete();
        do_txn(1'b1, 20'hFFFFF, 2'b10, 16'hA500, lat, rd);
        ref_mem[32'h1FFFFF] = 8'hA5;
        chk_cnt++; if (wr_log.size() !== SC || wr_log[0].a !== 21'h1FFFFF)
            $display("FAIL addr_wrap_pins: got %0d strobes want %0d at 1FFFFF", wr_log.size(), SC); else pass_cnt++;
        do_txn(1'b0, 20'hFFFFF, 2'b11, 16'h0000, lat, rd);
        model_rdata = {8'hA5, ref_rd(21'h1FFFFE)};
        chk_cnt++; if (rd !== model_rdata) $display("FAIL addr_wrap_read: got %h want %h", rd, model_rdata); else pass_cnt++;
    endtask

    task automatic test_be_zero();
        int lat;
        logic [15:0] rd;
        logic [AW-1:0] a_before;
        do_txn(1'b0, 20'h00010, 2'b01, 16'h0000, lat, rd);
        model_rdata = {8'h00, ref_rd(21'h20)};
        chk_cnt++; if (rd !== 16'h00EF) $display("FAIL low_byte_read: got %h want 00EF", rd); else pass_cnt++;
        chk_cnt++; if (lat !== 5) $display("FAIL low_byte_read_latency: got %0d want 5", lat); else pass_cnt++;
        wr_log.delete();
        a_before = SRAM_A;
        // Nothing to move on the pins: ack follows the accepting edge (req cycle + ack cycle).
        do_txn(1'b0, 20'h00300, 2'b00, 16'h0000, lat, rd);
        chk_cnt++; if (lat !== 1) $display("FAIL be00_read_latency: got %0d want 1", lat); else pass_cnt++;
        chk_cnt++; if (rd !== model_rdata) $display("FAIL be00_rdata_held: got %h want %h", rd, model_rdata); else pass_cnt++;
        chk_cnt++; if (SRAM_A !== a_before) $display("FAIL be00_addr_held: got %h want %h", SRAM_A, a_before); else pass_cnt++;
        do_txn(1'b1, 20'h00300, 2'b00, 16'hFFFF, lat, rd);
        chk_cnt++; if (lat !== 1 || wr_log.size() !== 0)
            $display("FAIL be00_write_quiet: got lat=%0d strobes=%0d want 1 0", lat, wr_log.size()); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int cyc, ack0, bad, lat;
        logic [15:0] rd;
        wr_log.delete();
        ack0 = ack_seen;
        @(negedge clk_100); #1;
        req = 1'b1; we = 1'b1; addr = 20'h00040; be = 2'b11; wdata = 16'h5AC3;
        @(posedge clk_100); #2;
        addr = 20'h00050; wdata = 16'h0F0F;
        cyc = 1;
        while (ack !== 1'b1 && cyc < 40) begin
            @(posedge clk_100); #2;
            cyc++;
        end
        chk_cnt++; if (cyc !== 9) $display("FAIL repulse_latency: got %0d want 9", cyc); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL repulse_busy_at_ack: got %b want 1", busy); else pass_cnt++;
        @(posedge clk_100); #2;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL repulse_idle_after_ack: got %b want 0", busy); else pass_cnt++;
        req = 1'b0;
        repeat (12) @(posedge clk_100);
        #2;
        ref_mem[32'h80] = 8'hC3;
        ref_mem[32'h81] = 8'h5A;
        chk_cnt++; if (ack_seen - ack0 !== 1) $display("FAIL repulse_ack_count: got %0d want 1", ack_seen - ack0); else pass_cnt++;
        bad = 0;
        foreach (wr_log[i]) if (wr_log[i].a !== 21'h80 && wr_log[i].a !== 21'h81) bad++;
        chk_cnt++; if (wr_log.size() !== 2 * SC || bad != 0)
            $display("FAIL repulse_single_txn: got %0d strobes %0d foreign want %0d 0", wr_log.size(), bad, 2 * SC); else pass_cnt++;
        chk_cnt++; if (sram_mem[32'h80] !== 8'hC3 || sram_mem[32'h81] !== 8'h5A)
            $display("FAIL repulse_mem: got %h%h want 5AC3", sram_mem[32'h81], sram_mem[32'h80]); else pass_cnt++;
        do_txn(1'b1, 20'h00050, 2'b11, 16'h0F0F, lat, rd);
        ref_mem[32'hA0] = 8'h0F;
        ref_mem[32'hA1] = 8'h0F;
        chk_cnt++; if (lat !== 9 || ack_seen - ack0 !== 2)
            $display("FAIL repulse_next_accept: got lat=%0d acks=%0d want 9 2", lat, ack_seen - ack0); else pass_cnt++;
    endtask

    task automatic test_reset_mid_write();
        int cyc, lat;
        logic [15:0] rd;
        @(negedge clk_100); #1;
        req = 1'b1; we = 1'b1; addr = 20'h00060; be = 2'b11; wdata = 16'h1357;
        @(posedge clk_100); #2;
        req = 1'b0;
        cyc = 1;
        while (SRAM_WE_n !== 1'b0 && cyc < 20) begin
            @(posedge clk_100); #2;
            cyc++;
        end
        chk_cnt++; if (cyc !== 2) $display("FAIL midreset_strobe_start: got cycle %0d want 2", cyc); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if (SRAM_WE_n !== 1'b1 || sram_dq_oe !== 1'b0 || busy !== 1'b0)
            $display("FAIL midreset_async: got we_n=%b oe=%b busy=%b want 1 0 0", SRAM_WE_n, sram_dq_oe, busy); else pass_cnt++;
        @(negedge clk_100);
        @(negedge clk_100);
        rst_n = 1'b1;
        model_rdata = 16'h0000;
        repeat (3) @(posedge clk_100);
        #2;
        chk_cnt++; if (busy !== 1'b0 || SRAM_WE_n !== 1'b1 || SRAM_A !== '0 || rdata !== 16'h0)
            $display("FAIL midreset_idle: got busy=%b we_n=%b a=%h rdata=%h want 0 1 0 0", busy, SRAM_WE_n, SRAM_A, rdata); else pass_cnt++;
        do_txn(1'b0, 20'h00010, 2'b11, 16'h0000, lat, rd);
        model_rdata = {ref_rd(21'h21), ref_rd(21'h20)};
        chk_cnt++; if (rd !== 16'hBEEF || lat !== 9)
            $display("FAIL midreset_followup_read: got %h lat=%0d want BEEF lat=9", rd, lat); else pass_cnt++;
    endtask

    task automatic test_random();
        int lat, oe0, idx, n_ok, nl;
        logic          t_we;
        logic [AW-2:0] t_addr;
        logic [1:0]    t_be;
        logic [15:0]   t_wd, rd, exp_rd;
        logic          lane_b;
        logic [AW-1:0] ba;
        for (int i = 0; i < 40; i++) begin
            t_we   = 1'($urandom_range(0, 1));
            t_addr = ($urandom_range(0, 7) == 0) ? '1 : (AW-1)'(20'h00100 + $urandom_range(0, 15));
            t_be   = 2'($urandom_range(0, 3));
            t_wd   = 16'($urandom);
            nl     = int'(t_be[0]) + int'(t_be[1]);
            wr_log.delete();
            oe0 = oe_cycles;
            do_txn(t_we, t_addr, t_be, t_wd, lat, rd);
            chk_cnt++; if (lat !== exp_lat(t_be))
                $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, exp_lat(t_be)); else pass_cnt++;
            if (t_we) begin
                n_ok = 1; idx = 0;
                for (int l = 0; l < 2; l++) begin
                    lane_b = 1'(l);
                    if (t_be[l]) begin
                        for (int k = 0; k < SC; k++) begin
                            if (idx >= wr_log.size()) n_ok = 0;
                            else if (wr_log[idx].a !== {t_addr, lane_b} ||
                                     wr_log[idx].d !== (lane_b ? t_wd[15:8] : t_wd[7:0])) n_ok = 0;
                            idx++;
                        end
                        ref_mem[int'({t_addr, lane_b})] = lane_b ? t_wd[15:8] : t_wd[7:0];
                    end
                end
                if (idx != wr_log.size()) n_ok = 0;
                chk_cnt++; if (n_ok != 1)
                    $display("FAIL rand%0d_write_pins: got %0d strobes want %0d a=%h be=%b", i, wr_log.size(), idx, t_addr, t_be); else pass_cnt++;
                chk_cnt++; if (oe_cycles - oe0 !== nl * (SC + 2))
                    $display("FAIL rand%0d_oe_cycles: got %0d want %0d", i, oe_cycles - oe0, nl * (SC + 2)); else pass_cnt++;
            end else begin
                if (t_be != 2'b00) begin
                    ba = {t_addr, 1'b0};
                    exp_rd[7:0]  = t_be[0] ? ref_rd(ba) : 8'h00;
                    ba = {t_addr, 1'b1};
                    exp_rd[15:8] = t_be[1] ? ref_rd(ba) : 8'h00;
                    model_rdata  = exp_rd;
                end
                chk_cnt++; if (rd !== model_rdata)
                    $display("FAIL rand%0d_read_data: got %h want %h a=%h be=%b", i, rd, model_rdata, t_addr, t_be); else pass_cnt++;
                chk_cnt++; if (oe_cycles !== oe0 || wr_log.size() !== 0)
                    $display("FAIL rand%0d_read_quiet: got oe=%0d strobes=%0d want 0 0", i, oe_cycles - oe0, wr_log.size()); else pass_cnt++;
            end
        end
        chk_cnt++; if (pin_race !== 0 || oe_bad !== 0 || we_no_oe !== 0)
            $display("FAIL rand_pin_rules: got race=%0d oe_at_ack=%0d we_no_oe=%0d want 0", pin_race, oe_bad, we_no_oe); else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200us want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_word_write();
        test_word_read();
        test_byte_write();
        test_be_zero();
        test_back_to_back();
        test_reset_mid_write();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
